// File: rtl/tns_tx_scheduler_pkg.sv
// Shared constants and types for the two-source TNS link scheduler.
// Widths follow the 12-bit, 4-group TNS encoder that consumes enc_data.
package tns_tx_scheduler_pkg;

    localparam int TNS_DATA_W    = 8;
    localparam int TNS_CODE_W    = 12;
    localparam int TNS_SEED_WORD = 0;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef enum logic {
        ST_SEED = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic valid;
        logic src;
    } tag_t;

    function automatic logic [3:0] burst_next(input logic [3:0] cnt, input logic [3:0] cap);
        return (cnt >= cap) ? cap : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/tns_tx_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter with a burst cap.
// The current owner keeps the grant under contention until it has taken MAX_BURST words.
module tns_rr_arb2
    import tns_tx_scheduler_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    localparam logic [3:0] CAP = 4'(MAX_BURST);

    logic       rr_last_q, rr_last_d;
    logic [3:0] burst_q, burst_d;
    logic       hold_owner;

    // A zero count means no burst is in progress, so the other source wins.
    assign hold_owner = (burst_q != 4'd0) && (burst_q < CAP);

    always_comb begin
        gnt_id = rr_last_q;
        case (req)
            2'b01:   gnt_id = SRC_A;
            2'b10:   gnt_id = SRC_B;
            2'b11:   gnt_id = hold_owner ? rr_last_q : ~rr_last_q;
            default: gnt_id = rr_last_q;
        endcase
        gnt = 2'b00;
        if (en && (req != 2'b00)) begin
            gnt = (gnt_id == SRC_B) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        burst_d   = burst_q;
        if (req == 2'b00) begin
            burst_d = 4'd0;
        end else if (gnt != 2'b00) begin
            burst_d   = (gnt_id == rr_last_q) ? burst_next(burst_q, CAP) : 4'd1;
            rr_last_d = gnt_id;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last_q <= SRC_B;
            burst_q   <= 4'd0;
        end else begin
            rr_last_q <= rr_last_d;
            burst_q   <= burst_d;
        end
    end

endmodule

// File: rtl/tns_tx_scheduler.sv
// Schedules words from sources A and B onto one TNS-encoded link, seeding the
// encoder history after reset and emitting tags aligned with the registered codeword.
module tns_tx_scheduler
    import tns_tx_scheduler_pkg::*;
#(
    parameter int DATA_W    = TNS_DATA_W,
    parameter int MAX_BURST = 4,
    parameter int SEED_CYC  = 2,
    parameter int SEED_WORD = TNS_SEED_WORD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              link_ready,
    output logic [DATA_W-1:0] enc_data,
    output logic              code_valid,
    output logic              code_src,
    output logic              busy_seed
);

    localparam int SEED_CW = (SEED_CYC > 1) ? $clog2(SEED_CYC) : 1;

    sched_state_e      state_q, state_d;
    logic [SEED_CW-1:0] seed_cnt_q, seed_cnt_d;
    logic [DATA_W-1:0] enc_data_q, enc_data_d;
    tag_t              tag1_q, tag1_d, tag2_q;
    logic [1:0]        gnt;
    logic              gnt_id;
    logic              arb_en;

    // Never grant while reset is asserted, even if the state register still says RUN.
    assign arb_en = (state_q == ST_RUN) && link_ready && !reset;

    tns_rr_arb2 #(
        .MAX_BURST(MAX_BURST)
    ) u_arb (
        .clock  (clock),
        .reset  (reset),
        .en     (arb_en),
        .req    ({b_valid, a_valid}),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        state_d    = state_q;
        seed_cnt_d = seed_cnt_q;
        enc_data_d = enc_data_q;
        tag1_d     = '{valid: 1'b0, src: SRC_A};
        case (state_q)
            ST_SEED: begin
                enc_data_d = DATA_W'(SEED_WORD);
                seed_cnt_d = seed_cnt_q + 1'b1;
                if (seed_cnt_q == SEED_CW'(SEED_CYC - 1)) begin
                    state_d    = ST_RUN;
                    seed_cnt_d = '0;
                end
            end
            ST_RUN: begin
                // Without an accept enc_data holds, so the link sees no toggles.
                if (gnt != 2'b00) begin
                    enc_data_d = (gnt_id == SRC_B) ? b_data : a_data;
                    tag1_d     = '{valid: 1'b1, src: gnt_id};
                end
            end
            default: state_d = ST_SEED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_SEED;
            seed_cnt_q <= '0;
            enc_data_q <= DATA_W'(SEED_WORD);
            tag1_q     <= '0;
            tag2_q     <= '0;
        end else begin
            state_q    <= state_d;
            seed_cnt_q <= seed_cnt_d;
            enc_data_q <= enc_data_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
        end
    end

    assign a_ready    = gnt[0];
    assign b_ready    = gnt[1];
    assign enc_data   = enc_data_q;
    assign code_valid = tag2_q.valid;
    assign code_src   = tag2_q.src;
    assign busy_seed  = (state_q == ST_SEED);

endmodule

// File: tb/tb_tns_tx_scheduler.sv
// Self-checking bench for tns_tx_scheduler: scenario tasks against a cycle-level
// behavioural model plus an end-to-end scoreboard of accepted words.
module tb_tns_tx_scheduler;
    import tns_tx_scheduler_pkg::*;

    localparam int DW = TNS_DATA_W;
    localparam int MB = 4;
    localparam int SC = 2;
    localparam int SW = 0;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          a_valid = 1'b0;
    logic          b_valid = 1'b0;
    logic          link_ready = 1'b1;
    logic [DW-1:0] a_data = '0;
    logic [DW-1:0] b_data = '0;
    logic          a_ready, b_ready, code_valid, code_src, busy_seed;
    logic [DW-1:0] enc_data;

    tns_tx_scheduler #(
        .DATA_W(DW), .MAX_BURST(MB), .SEED_CYC(SC), .SEED_WORD(SW)
    ) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .link_ready(link_ready), .enc_data(enc_data),
        .code_valid(code_valid), .code_src(code_src), .busy_seed(busy_seed)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Model: seed cycles left, last granted source, current run length, tag delay line.
    int            seed_left, last_src, run_len, p1_v, p1_s, m_cv, m_cs;
    logic          m_ar, m_br;
    logic [DW-1:0] m_enc, prev_enc;
    int            sb_src[$];
    logic [DW-1:0] sb_dat[$];
    logic          sb_hit;
    int            sb_exp_s;
    logic [DW-1:0] sb_exp_d;

    function automatic logic [DW+4:0] obs_vec();
        logic cs;
        cs = (m_cv != 0) ? code_src : 1'b0;
        return {a_ready, b_ready, busy_seed, code_valid, cs, enc_data};
    endfunction

    function automatic logic [DW+4:0] exp_vec();
        logic cs;
        cs = (m_cv != 0) ? m_cs[0] : 1'b0;
        return {m_ar, m_br, logic'(seed_left > 0), logic'(m_cv != 0), cs, m_enc};
    endfunction

    task automatic settle();
        int pick;
        #1;
        pick = -1;
        if (!reset && seed_left == 0 && link_ready) begin
            if (a_valid && b_valid) pick = (run_len > 0 && run_len < MB) ? last_src : 1 - last_src;
            else if (a_valid) pick = 0;
            else if (b_valid) pick = 1;
        end
        m_ar = (pick == 0);
        m_br = (pick == 1);
        sb_hit = 1'b0;
        if (code_valid === 1'b1 && sb_src.size() > 0) begin
            sb_hit   = 1'b1;
            sb_exp_s = sb_src.pop_front();
            sb_exp_d = sb_dat.pop_front();
        end
    endtask

    task automatic model_update();
        int s;
        if (reset) begin
            seed_left = SC; last_src = 1; run_len = 0;
            p1_v = 0; p1_s = 0; m_cv = 0; m_cs = 0;
            m_enc = DW'(SW);
            sb_src.delete(); sb_dat.delete();
        end else begin
            m_cv = p1_v; m_cs = p1_s;
            p1_v = 0; p1_s = 0;
            if (seed_left > 0) begin
                seed_left--;
                m_enc = DW'(SW);
            end else if (m_ar || m_br) begin
                s = m_br ? 1 : 0;
                m_enc = m_br ? b_data : a_data;
                p1_v = 1; p1_s = s;
                run_len = (s == last_src) ? ((run_len >= MB) ? MB : run_len + 1) : 1;
                last_src = s;
            end
            if (!a_valid && !b_valid) run_len = 0;
        end
    endtask

    task automatic end_cycle();
        if (a_valid && a_ready === 1'b1) begin sb_src.push_back(0); sb_dat.push_back(a_data); end
        if (b_valid && b_ready === 1'b1) begin sb_src.push_back(1); sb_dat.push_back(b_data); end
        prev_enc = enc_data;
        @(posedge clock);
        model_update();
        cyc++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            reset = 1'b1; a_valid = 1'b1; a_data = DW'('h33); b_valid = 1'b0; link_ready = 1'b1;
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL reset_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if ({a_ready, b_ready, code_valid, busy_seed, enc_data} !== {1'b0, 1'b0, 1'b0, 1'b1, DW'(SW)}) begin
                fails++; $display("FAIL reset_values c%0d: got ar=%b br=%b cv=%b busy=%b enc=%h want 0 0 0 1 %h",
                                  cyc, a_ready, b_ready, code_valid, busy_seed, enc_data, DW'(SW));
            end
            end_cycle();
        end
    endtask

    task automatic test_seed();
        int first = -1;
        int cv_at = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            reset = 1'b0; a_valid = (first < 0); a_data = DW'('h21);
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL seed_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (i <= SC) begin
                checks++;
                if (a_ready !== 1'b0 || enc_data !== DW'(SW)) begin
                    fails++; $display("FAIL seed_hold c%0d: got ar=%b enc=%h want ar=0 enc=%h", cyc, a_ready, enc_data, DW'(SW));
                end
            end
            if (a_ready === 1'b1 && first < 0) first = i;
            if (code_valid === 1'b1 && cv_at < 0) begin
                cv_at = i;
                checks++;
                if (code_src !== SRC_A || prev_enc !== DW'('h21)) begin
                    fails++; $display("FAIL seed_first_code: got src=%b word=%h want src=0 word=21", code_src, prev_enc);
                end
            end
            end_cycle();
        end
        checks++;
        if (first != SC + 1) begin
            fails++; $display("FAIL seed_first_ready: got cycle %0d want %0d", first, SC + 1);
        end
        checks++;
        if (cv_at != first + 2) begin
            fails++; $display("FAIL seed_code_latency: got cycle %0d want %0d", cv_at, first + 2);
        end
    endtask

    task automatic test_single_source();
        int k = 5;
        int nrdy = 0;
        int rdy_first = -1;
        int rdy_last = -1;
        logic [DW-1:0] got[$];
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            a_valid = 1'b0; b_valid = (k <= 10); b_data = DW'(k);
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL single_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (sb_hit) begin
                checks++;
                if ({code_src, prev_enc} !== {sb_exp_s[0], sb_exp_d}) begin
                    fails++; $display("FAIL single_sb c%0d: got src=%b word=%h want src=%b word=%h",
                                      cyc, code_src, prev_enc, sb_exp_s[0], sb_exp_d);
                end
            end
            if (b_ready === 1'b1) begin
                nrdy++;
                if (rdy_first < 0) rdy_first = i;
                rdy_last = i;
            end
            if (code_valid === 1'b1) begin
                got.push_back(prev_enc);
                checks++;
                if (code_src !== SRC_B) begin
                    fails++; $display("FAIL single_src c%0d: got %b want 1", cyc, code_src);
                end
            end
            if (b_valid && b_ready === 1'b1) k++;
            end_cycle();
        end
        checks++;
        if (nrdy != 6 || rdy_last - rdy_first != 5) begin
            fails++; $display("FAIL single_ready_run: got %0d readies over span %0d want 6 consecutive", nrdy, rdy_last - rdy_first + 1);
        end
        checks++;
        if (got.size() != 6) begin
            fails++; $display("FAIL single_code_count: got %0d want 6", got.size());
        end
        for (int j = 0; j < got.size(); j++) begin
            checks++;
            if (got[j] !== DW'(5 + j)) begin
                fails++; $display("FAIL single_order idx%0d: got %h want %h", j, got[j], DW'(5 + j));
            end
        end
    endtask

    task automatic test_contention();
        logic [11:0] pat;
        logic [11:0] want;
        int ng = 0;
        pat  = '0;
        want = 12'b0000_1111_0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            a_valid = (ng < 12); b_valid = (ng < 12);
            a_data = DW'($urandom); b_data = DW'($urandom);
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL contention_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (a_ready === 1'b1 && b_ready === 1'b1) begin
                fails++; $display("FAIL contention_both_ready c%0d: got 11 want at most one", cyc);
            end
            if (sb_hit) begin
                checks++;
                if ({code_src, prev_enc} !== {sb_exp_s[0], sb_exp_d}) begin
                    fails++; $display("FAIL contention_sb c%0d: got src=%b word=%h want src=%b word=%h",
                                      cyc, code_src, prev_enc, sb_exp_s[0], sb_exp_d);
                end
            end
            if (ng < 12 && (a_ready === 1'b1 || b_ready === 1'b1)) begin
                pat[ng] = b_ready;
                ng++;
            end
            end_cycle();
        end
        checks++;
        if (ng != 12 || pat !== want) begin
            fails++; $display("FAIL contention_pattern: got %0d grants pattern %b want 12 grants %b (bit0 first, 1=B)", ng, pat, want);
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        logic [DW-1:0] held;
        logic [DW-1:0] got[$];
        held = '0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            a_valid = (k < 8); a_data = DW'('h40 + k); b_valid = 1'b0;
            link_ready = !(i >= 3 && i <= 5);
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL backpressure_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (i == 3) held = enc_data;
            if (i >= 3 && i <= 5) begin
                checks++;
                if (a_ready !== 1'b0) begin
                    fails++; $display("FAIL backpressure_ready c%0d: got %b want 0", cyc, a_ready);
                end
            end
            if (i >= 4 && i <= 6) begin
                checks++;
                if (enc_data !== held) begin
                    fails++; $display("FAIL backpressure_hold c%0d: got %h want %h", cyc, enc_data, held);
                end
            end
            if (code_valid === 1'b1) got.push_back(prev_enc);
            if (a_valid && a_ready === 1'b1) k++;
            end_cycle();
        end
        link_ready = 1'b1;
        checks++;
        if (got.size() != 8) begin
            fails++; $display("FAIL backpressure_count: got %0d words want 8", got.size());
        end
        for (int j = 0; j < got.size(); j++) begin
            checks++;
            if (got[j] !== DW'('h40 + j)) begin
                fails++; $display("FAIL backpressure_order idx%0d: got %h want %h", j, got[j], DW'('h40 + j));
            end
        end
    endtask

    task automatic test_idle_hold();
        int sent = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            a_valid = (sent == 0); a_data = DW'('h1F); b_valid = 1'b0; link_ready = 1'b1;
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL idle_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (i >= 3) begin
                checks++;
                if (enc_data !== DW'('h1F) || code_valid !== 1'b0) begin
                    fails++; $display("FAIL idle_hold c%0d: got enc=%h cv=%b want enc=1f cv=0", cyc, enc_data, code_valid);
                end
            end
            if (a_valid && a_ready === 1'b1) sent = 1;
            end_cycle();
        end
        checks++;
        if (sent != 1) begin
            fails++; $display("FAIL idle_send: got accepted=%0d want 1", sent);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            a_valid = (i < 396) && ($urandom_range(0, 3) != 0);
            b_valid = (i < 396) && ($urandom_range(0, 3) != 0);
            link_ready = ($urandom_range(0, 4) != 0);
            a_data = DW'($urandom); b_data = DW'($urandom);
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL random_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (sb_hit) begin
                checks++;
                if ({code_src, prev_enc} !== {sb_exp_s[0], sb_exp_d}) begin
                    fails++; $display("FAIL random_sb c%0d: got src=%b word=%h want src=%b word=%h",
                                      cyc, code_src, prev_enc, sb_exp_s[0], sb_exp_d);
                end
            end
            end_cycle();
        end
        link_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int hs = -1;
        logic in_rst;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            in_rst = (hs >= 0) && (i == hs + 1);
            reset = in_rst;
            a_valid = (hs < 0) || in_rst;
            a_data = in_rst ? DW'('h66) : DW'('h55);
            b_valid = 1'b0; link_ready = 1'b1;
            settle();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL reset_mid_model c%0d: got %h want %h", cyc, obs_vec(), exp_vec());
            end
            if (in_rst) begin
                checks++;
                if (a_ready !== 1'b0) begin
                    fails++; $display("FAIL reset_mid_no_ack c%0d: got %b want 0", cyc, a_ready);
                end
            end
            if (hs >= 0 && i == hs + 2) begin
                checks++;
                if (code_valid !== 1'b0 || busy_seed !== 1'b1 || enc_data !== DW'(SW)) begin
                    fails++; $display("FAIL reset_mid_flush c%0d: got cv=%b busy=%b enc=%h want 0 1 %h",
                                      cyc, code_valid, busy_seed, enc_data, DW'(SW));
                end
            end
            if (hs < 0 && a_valid && a_ready === 1'b1) hs = i;
            end_cycle();
        end
        reset = 1'b0;
        checks++;
        if (hs < 0) begin
            fails++; $display("FAIL reset_mid_handshake: got none want one within 12 cycles");
        end
    endtask

    initial begin
        seed_left = SC; last_src = 1; run_len = 0;
        p1_v = 0; p1_s = 0; m_cv = 0; m_cs = 0;
        m_enc = DW'(SW); prev_enc = '0;
        m_ar = 1'b0; m_br = 1'b0; sb_hit = 1'b0; sb_exp_s = 0; sb_exp_d = '0;
        @(posedge clock);
        model_update();
        test_reset();
        test_seed();
        test_single_source();
        test_contention();
        test_backpressure();
        test_idle_hold();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tns_tx_scheduler.md
Name: tns_tx_scheduler

Overview:
- Feeds the 12-bit, 4-group TNS encoder on one shared encoded link from two independent word sources (A, B).
- Round-robin arbitration with a burst cap, valid/ready handshakes on both sources, and link back-pressure.
- After reset, seeds the encoder's per-group history bits with a known word before any user data is sent.
- Drives the encoder's data input, which is held stable whenever nothing is sent. Emits sideband tags aligned with the encoder's one-cycle registered codeword output.

Parameters:
- DATA_W, `BLEN04 (TNS.vh): source and encoder data width.
- MAX_BURST, 4: maximum consecutive words granted to one source while the other is requesting; range 1..15.
- SEED_CYC, 2: number of cycles SEED_WORD is driven after reset; must be ≥ 2.
- SEED_WORD, 0: value driven during seeding; must be < TNS total range.

Ports:
- clock, in, 1: single clock; all state on posedge.
- reset, in, 1: synchronous, active-high.
- a_valid, in, 1: source A has a word.
- a_data, in, DATA_W: source A word.
- a_ready, out, 1: A word accepted this cycle when a_valid & a_ready.
- b_valid, in, 1: source B has a word.
- b_data, in, DATA_W: source B word.
- b_ready, out, 1: B word accepted this cycle when b_valid & b_ready.
- link_ready, in, 1: link can take a new codeword next cycle.
- enc_data, out, DATA_W: to encoder datain.
- code_valid, out, 1: encoder codeout this cycle carries a fresh user word.
- code_src, out, 1: source of that word; 0 = A, 1 = B.
- busy_seed, out, 1: high while seeding.

Behaviour:
- Reset (synchronous, active-high) values:
  - state = SEED, seed counter = 0, enc_data = SEED_WORD.
  - a_ready = b_ready = 0, code_valid = 0, code_src = 0.
  - rr_last = 1, so A wins first; burst counter = 0.
- Assertion mid-transfer drops any in-flight tag. No word is accepted in a cycle where reset is high.
- States:
  - SEED: enc_data = SEED_WORD, busy_seed = 1, readies 0. Counter increments every cycle regardless of link_ready. At count SEED_CYC-1, go to RUN.
  - RUN: arbitrate each cycle.
- Grant is combinational in RUN, when link_ready = 1:
  - Only one source valid: grant it.
  - Both valid: grant the source ≠ rr_last. If burst count < MAX_BURST, keep the current owner (rr_last) instead.
- a_ready / b_ready:
  - = grant for that source; at most one high per cycle.
  - Both 0 when link_ready = 0, in SEED, or in reset.
- On accept:
  - enc_data <= granted data.
  - Tag pipe stage 1 <= {1, src}.
  - Burst count <= (src == rr_last) ? count+1 : 1; rr_last <= src.
- No accept: enc_data holds its previous value. This gives zero bus toggles, and the encoder history stays consistent. Stage 1 valid <= 0.
- Burst count resets to 0 when neither source is valid.
- Encoder output alignment:
  - Encoder registers codeout one cycle after enc_data.
  - enc_data is itself registered here, so code_valid/code_src are stage 1 delayed one more register.
  - Word accepted at edge N appears on enc_data after N and on codeout after N+1. code_valid is high in that same cycle.
- Back-pressure: link_ready is sampled in the accept cycle only. Words already in the tag pipe always complete; no flush.
- Simultaneous events:
  - Both valid with link_ready low: nothing is granted and rr_last is unchanged.
  - A source deasserting valid without a handshake is legal.
- Width: enc_data is exactly DATA_W; no arithmetic on data. The burst counter is 4 bits and saturates at MAX_BURST.

Decomposition:
- Shared package, TNS.vh additions:
  - `TNS_SEED_WORD
  - `TNS_CODE_W (12)
  - source IDs `SRC_A / `SRC_B
- Sub-module tns_rr_arb2: two-requester round-robin arbiter with burst cap. Inputs req[1:0], en, clock, reset. Outputs gnt[1:0], gnt_id.
- Top instantiates tns_rr_arb2 and optionally the encoder in a bench wrapper.

Test Plan:
- Seed: reset high 3 cycles, then low, with a_valid = 1 → a_ready = 0 for exactly SEED_CYC = 2 cycles. enc_data = 0 throughout. First a_ready = 1 in cycle 3. First code_valid 2 cycles after accept, with code_src = 0.
- Single source: b_valid steady, 6 words 5..10, link_ready = 1 → b_ready is high 6 consecutive cycles. code_valid pulses 6 cycles with code_src = 1. The encoder decodes back to 5..10 in order.
- Contention: A and B valid continuously, MAX_BURST = 4 → grant pattern AAAABBBBAAAA. Never both readies high.
- Back-pressure: link_ready low for 3 cycles mid-stream → no ready, enc_data is unchanged, and codeout is stable. Stream resumes with no loss or duplication.
- Idle hold: last word 0x1F, then sources idle 5 cycles → enc_data stays 0x1F, code_valid = 0, and codeout has zero bit transitions.
- Reset mid-operation: reset asserted for 1 cycle while a code_valid is pending → code_valid = 0 next cycle. Seeding restarts, and the word presented during reset is not acknowledged.
